// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - parametrised multi-port register file with busy scoreboard
//
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   we_i        per-write-port enable
//   waddr_i     write addresses, port w at [w*AW +: AW]
//   wdata_i     write data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   raddr_i     read addresses, port k at [k*AW +: AW]
//   rdata_o     read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rsv_i       reserve request (marks rsv_addr_i busy)
//   rsv_addr_i  register to reserve
//   busy_o      busy flag of the register addressed by each read port
//   busy_cnt_o  registered count of busy registers
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RD_REG     = 0,
    localparam int AW = $clog2(REG_COUNT),
    localparam int CW = $clog2(REG_COUNT + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR*AW-1:0]           waddr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_RD*AW-1:0]           raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata_o,
    input  logic                           rsv_i,
    input  logic [AW-1:0]                  rsv_addr_i,
    output logic [NUM_RD-1:0]              busy_o,
    output logic [CW-1:0]                  busy_cnt_o
);

    logic [DATA_WIDTH-1:0]        regs_q [REG_COUNT];
    logic [REG_COUNT-1:0]         busy_q;
    logic [REG_COUNT-1:0]         busy_d;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_d;

    logic [AW-1:0]                wa [NUM_WR];
    logic [DATA_WIDTH-1:0]        wd [NUM_WR];
    logic [AW-1:0]                ra [NUM_RD];
    logic [NUM_WR-1:0]            wr_en;
    logic                         rsv_en;
    logic [REG_COUNT-1:0]         wr_hit;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_comb;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wa[w] = waddr_i[w*AW +: AW];
        assign wd[w] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        // Writes to the hardwired zero register are dropped here, so nothing
        // downstream (array, bypass, scoreboard) ever sees them.
        assign wr_en[w] = we_i[w] && !((ZERO_REG != 0) && (wa[w] == '0));
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
        assign ra[k] = raddr_i[k*AW +: AW];
    end

    assign rsv_en = rsv_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    // Per-register "written this cycle" flags, used by bypassed busy_o.
    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                wr_hit[wa[w]] = 1'b1;
            end
        end
    end

    // Scoreboard next state: writes clear, then reserve sets, so a reserve
    // to the same register in the same cycle wins over the writeback.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_d[wa[w]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    // Loop order makes the highest-index write port win on address clashes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w]) begin
                    regs_q[wa[w]] <= wd[w];
                end
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_comb = '0;
        busy_o  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_comb[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra[k]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wa[w] == ra[k])) begin
                        rd_comb[k*DATA_WIDTH +: DATA_WIDTH] = wd[w];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra[k] == '0)) begin
                rd_comb[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end

            busy_o[k] = busy_q[ra[k]];
            // A writeback landing this cycle frees the register early unless
            // it is being re-reserved in the same cycle.
            if ((BYPASS != 0) && wr_hit[ra[k]] && !(rsv_en && (rsv_addr_i == ra[k]))) begin
                busy_o[k] = 1'b0;
            end
        end
    end

    assign busy_cnt_o = cnt_q;

    if (RD_REG != 0) begin : g_rd_reg
        logic [NUM_RD*DATA_WIDTH-1:0] rdata_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rd_comb;
            end
        end
        assign rdata_o = rdata_q;
    end else begin : g_rd_comb
        assign rdata_o = rd_comb;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp in three configurations
module tb_register_file_mp;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  we = '0;
    logic [4:0]  wa0 = '0, wa1 = '0, ra0 = '0, ra1 = '0, rsv_a = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        rsv = 1'b0;

    logic [9:0]  waddr, raddr;
    logic [63:0] wdata;
    assign waddr = {wa1, wa0};
    assign raddr = {ra1, ra0};
    assign wdata = {wd1, wd0};

    logic [63:0] a_rdata, b_rdata, c_rdata;
    logic [1:0]  a_busy, b_busy, c_busy;
    logic [5:0]  a_cnt, b_cnt, c_cnt;

    always #5 clk_i = ~clk_i;

    // a: bypass, combinational read; b: no bypass; c: bypass, registered read
    register_file_mp #(.BYPASS(1), .RD_REG(0)) u_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(a_rdata), .rsv_i(rsv), .rsv_addr_i(rsv_a),
        .busy_o(a_busy), .busy_cnt_o(a_cnt));
    register_file_mp #(.BYPASS(0), .RD_REG(0)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(b_rdata), .rsv_i(rsv), .rsv_addr_i(rsv_a),
        .busy_o(b_busy), .busy_cnt_o(b_cnt));
    register_file_mp #(.BYPASS(1), .RD_REG(1)) u_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(c_rdata), .rsv_i(rsv), .rsv_addr_i(rsv_a),
        .busy_o(c_busy), .busy_cnt_o(c_cnt));

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;
    logic [5:0]  mcnt;
    logic [63:0] c_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = mregs[a];
        if (byp) begin
            if (we[0] && wa0 == a) v = wd0;
            if (we[1] && wa1 == a) v = wd1;
        end
        return v;
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        logic b;
        b = mbusy[a];
        if (byp && a != 5'd0 && ((we[0] && wa0 == a) || (we[1] && wa1 == a))
            && !(rsv && rsv_a == a)) b = 1'b0;
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mbusy = '0;
        mcnt  = '0;
    endtask

    task automatic m_update();
        if (we[0] && wa0 != 5'd0) begin mregs[wa0] = wd0; mbusy[wa0] = 1'b0; end
        if (we[1] && wa1 != 5'd0) begin mregs[wa1] = wd1; mbusy[wa1] = 1'b0; end
        if (rsv && rsv_a != 5'd0) mbusy[rsv_a] = 1'b1;
        mcnt = '0;
        for (int i = 0; i < 32; i++) mcnt = mcnt + 6'(mbusy[i]);
    endtask

    task automatic idle();
        we  = '0;
        rsv = 1'b0;
    endtask

    // Inputs are set by the caller at a negedge; checks combinational outputs,
    // queues the registered-read expectation, clocks, then checks it.
    task automatic cycle();
        logic [63:0] e;
        #1;
        check("a_rd0", {32'd0, a_rdata[31:0]},  {32'd0, m_read(ra0, 1'b1)});
        check("a_rd1", {32'd0, a_rdata[63:32]}, {32'd0, m_read(ra1, 1'b1)});
        check("b_rd0", {32'd0, b_rdata[31:0]},  {32'd0, m_read(ra0, 1'b0)});
        check("b_rd1", {32'd0, b_rdata[63:32]}, {32'd0, m_read(ra1, 1'b0)});
        check("a_busy", {62'd0, a_busy}, {62'd0, m_busy(ra1, 1'b1), m_busy(ra0, 1'b1)});
        check("b_busy", {62'd0, b_busy}, {62'd0, m_busy(ra1, 1'b0), m_busy(ra0, 1'b0)});
        check("c_busy", {62'd0, c_busy}, {62'd0, m_busy(ra1, 1'b1), m_busy(ra0, 1'b1)});
        check("a_cnt", {58'd0, a_cnt}, {58'd0, mcnt});
        check("b_cnt", {58'd0, b_cnt}, {58'd0, mcnt});
        check("c_cnt", {58'd0, c_cnt}, {58'd0, mcnt});
        c_q.push_back({m_read(ra1, 1'b1), m_read(ra0, 1'b1)});
        @(posedge clk_i);
        m_update();
        #1;
        if (c_q.size() == 0) begin
            check("c_queue_empty", 64'd1, 64'd0);
        end else begin
            e = c_q.pop_front();
            check("c_rd", c_rdata, e);
        end
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #3;
        check("rst_c_rdata", c_rdata, 64'd0);
        check("rst_a_cnt", {58'd0, a_cnt}, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // read every address on both ports straight after reset
        idle();
        for (int i = 0; i < 16; i++) begin
            ra0 = 5'(i);
            ra1 = 5'(i + 16);
            cycle();
        end

        // same-address double write: port 1 wins
        we = 2'b11; wa0 = 5'd5; wa1 = 5'd5; wd0 = 32'hDEADBEEF; wd1 = 32'h12345678;
        ra0 = 5'd5; ra1 = 5'd5;
        cycle();
        idle();
        #1;
        check("r5_port0", {32'd0, a_rdata[31:0]},  64'h12345678);
        check("r5_port1", {32'd0, b_rdata[63:32]}, 64'h12345678);
        cycle();

        // write r3 while reading r3: bypass vs old value
        we = 2'b01; wa0 = 5'd3; wd0 = 32'hA5A5A5A5; ra0 = 5'd3; ra1 = 5'd3;
        #1;
        check("byp_r3", {32'd0, a_rdata[31:0]}, 64'hA5A5A5A5);
        check("nobyp_r3", {32'd0, b_rdata[31:0]}, 64'h0);
        cycle();
        idle();
        cycle();

        // zero register ignores writes and reservations
        we = 2'b11; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'hFFFFFFFF; wd1 = 32'hFFFFFFFF;
        rsv = 1'b1; rsv_a = 5'd0; ra0 = 5'd0; ra1 = 5'd0;
        cycle();
        idle();
        cycle();

        // scoreboard sequence
        ra0 = 5'd7; ra1 = 5'd9;
        rsv = 1'b1; rsv_a = 5'd7;
        cycle();
        rsv_a = 5'd9;
        cycle();
        rsv = 1'b0;
        #1;
        check("cnt_two", {58'd0, a_cnt}, 64'd2);
        we = 2'b01; wa0 = 5'd7; wd0 = 32'h00000077;
        cycle();
        we = 2'b10; wa1 = 5'd9; wd1 = 32'h00000099; rsv = 1'b1; rsv_a = 5'd9;
        cycle();
        idle();
        #1;
        check("cnt_one", {58'd0, a_cnt}, 64'd1);
        check("r9_data", {32'd0, a_rdata[63:32]}, 64'h99);
        check("r9_busy", {62'd0, a_busy}, 64'b10);
        cycle();

        // random traffic
        for (int n = 0; n < 200; n++) begin
            we    = 2'($urandom_range(0, 3));
            wa0   = 5'($urandom_range(0, 31));
            wa1   = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0   = $urandom;
            wd1   = $urandom;
            rsv   = ($urandom_range(0, 2) == 0);
            rsv_a = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            ra0   = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
            ra1   = ($urandom_range(0, 1) == 0) ? rsv_a : 5'($urandom_range(0, 31));
            cycle();
        end

        // registered read: sample r5 at one edge, value appears right after it
        idle();
        we = 2'b01; wa0 = 5'd5; wd0 = 32'hC0FFEE05; rsv = 1'b1; rsv_a = 5'd6;
        cycle();
        idle();
        ra0 = 5'd5; ra1 = 5'd6;
        cycle();
        check("c_r5", {32'd0, c_rdata[31:0]}, 64'hC0FFEE05);

        // asynchronous reset between edges
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_c_rdata", c_rdata, 64'd0);
        check("mid_rst_a_rdata", a_rdata, 64'd0);
        check("mid_rst_busy", {62'd0, a_busy}, 64'd0);
        check("mid_rst_cnt", {58'd0, a_cnt}, 64'd0);
        m_reset();
        c_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra0 = 5'(i + 4);
            ra1 = 5'(i + 5);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
